// File: rtl/osd_dem_uart_bus_arb_if.sv
// rtl/osd_dem_uart_bus_arb_if.sv - requester-side and 16550-bus-side signal bundle for the UART bus arbiter
interface osd_dem_uart_bus_arb_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]   m_req;
    logic [3*NUM_MASTERS-1:0] m_addr;
    logic [NUM_MASTERS-1:0]   m_write;
    logic [8*NUM_MASTERS-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]   m_ack;
    logic [NUM_MASTERS-1:0]   m_err;
    logic [7:0]               m_rdata;
    logic                     bus_req;
    logic [2:0]               bus_addr;
    logic                     bus_write;
    logic [7:0]               bus_wdata;
    logic                     bus_ack;
    logic [7:0]               bus_rdata;

    // arbiter view
    modport slave (
        input  m_req, m_addr, m_write, m_wdata, bus_ack, bus_rdata,
        output m_ack, m_err, m_rdata, bus_req, bus_addr, bus_write, bus_wdata
    );

    // requester and 16550 register-bus view
    modport master (
        output m_req, m_addr, m_write, m_wdata, bus_ack, bus_rdata,
        input  m_ack, m_err, m_rdata, bus_req, bus_addr, bus_write, bus_wdata
    );
endinterface

// File: rtl/osd_dem_uart_bus_arb.sv
// rtl/osd_dem_uart_bus_arb.sv - round-robin arbiter with watchdog for the 16550 emulation register bus
module osd_dem_uart_bus_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    osd_dem_uart_bus_arb_if.slave  bus,
    output logic                   grant_valid,
    output logic [2:0]             grant_idx
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [2:0]  r_rr_ptr;
    logic [2:0]  r_grant_idx;
    logic        r_grant_valid;
    logic [15:0] r_cnt;

    logic        w_busy;
    logic        w_any;
    logic [2:0]  w_sel;
    logic        w_g_req;
    logic        w_g_write;
    logic [2:0]  w_g_addr;
    logic [7:0]  w_g_wdata;
    logic        w_done_ack;
    logic        w_done_err;
    logic [2:0]  w_next_ptr;

    assign w_busy = (r_state == S_BUSY);

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        w_any = 1'b0;
        w_sel = 3'd0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!w_any && (i == (int'(r_rr_ptr) + k) % NUM_MASTERS) && bus.m_req[i]) begin
                    w_any = 1'b1;
                    w_sel = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_g_req   = 1'b0;
        w_g_write = 1'b0;
        w_g_addr  = 3'd0;
        w_g_wdata = 8'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant_idx == 3'(i)) begin
                w_g_req   = bus.m_req[i];
                w_g_write = bus.m_write[i];
                w_g_addr  = bus.m_addr[3*i +: 3];
                w_g_wdata = bus.m_wdata[8*i +: 8];
            end
        end
    end

    // an ack coinciding with the watchdog expiry takes priority
    assign w_done_ack = w_busy && w_g_req && bus.bus_ack;
    assign w_done_err = w_busy && w_g_req && !bus.bus_ack && (r_cnt == 16'(TIMEOUT - 1));
    assign w_next_ptr = (r_grant_idx == 3'(NUM_MASTERS - 1)) ? 3'd0 : r_grant_idx + 3'd1;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_ack[i] = w_done_ack && (r_grant_idx == 3'(i));
            bus.m_err[i] = w_done_err && (r_grant_idx == 3'(i));
        end
    end

    assign bus.m_rdata   = bus.bus_rdata;
    assign bus.bus_req   = w_busy && w_g_req;
    assign bus.bus_addr  = w_busy ? w_g_addr  : 3'd0;
    assign bus.bus_write = w_busy ? w_g_write : 1'b0;
    assign bus.bus_wdata = w_busy ? w_g_wdata : 8'd0;

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 3'd0;
            r_grant_idx   <= 3'd0;
            r_grant_valid <= 1'b0;
            r_cnt         <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_idx   <= w_sel;
                        r_grant_valid <= 1'b1;
                        r_cnt         <= 16'd0;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // a dropped request is an abort: release without ack or err
                    if (!w_g_req || w_done_ack || w_done_err) begin
                        r_state       <= S_IDLE;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osd_dem_uart_bus_arb.sv
// tb/tb_osd_dem_uart_bus_arb.sv - randomized bench for the UART bus arbiter against a transaction-level model
module tb_osd_dem_uart_bus_arb;
    localparam int N  = 3;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       grant_valid;
    logic [2:0] grant_idx;

    osd_dem_uart_bus_arb_if #(.NUM_MASTERS(N)) bif();

    osd_dem_uart_bus_arb #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bif),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: who owns the bus, how long, and where the next search starts
    int          owner;
    int          age;
    int          ptr;
    int          last;
    logic [N-1:0] req;
    logic [2:0]  addr [N];
    logic [7:0]  wd   [N];
    logic        wr   [N];
    logic        ack;
    logic [7:0]  rdata;

    task automatic drive();
        bif.m_req = req;
        for (int i = 0; i < N; i++) begin
            bif.m_addr[3*i +: 3]  = addr[i];
            bif.m_write[i]        = wr[i];
            bif.m_wdata[8*i +: 8] = wd[i];
        end
        bif.bus_ack   = ack;
        bif.bus_rdata = rdata;
    endtask

    task automatic new_request(input int i);
        req[i]  = 1'b1;
        addr[i] = 3'($urandom_range(7));
        wd[i]   = 8'($urandom_range(255));
        wr[i]   = 1'($urandom_range(1));
    endtask

    initial begin
        logic         exp_breq;
        logic [11:0]  exp_drive;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_err;
        int           phase;

        owner = -1; age = 0; ptr = 0; last = 0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) new_request(i);
        ack = 1'b1;
        rdata = 8'h5a;
        drive();
        repeat (3) @(negedge clk);
        #1;
        check("rst_bus_req", 32'(bif.bus_req), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_m_ack", 32'(bif.m_ack), 32'd0);
        check("rst_m_err", 32'(bif.m_err), 32'd0);
        check("rst_bus_drive", {20'd0, bif.bus_addr, bif.bus_write, bif.bus_wdata}, 32'd0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            phase = cyc / 1000;
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(2) == 0) new_request(i);
            if (owner >= 0 && req[owner] && $urandom_range(99) == 0) req[owner] = 1'b0;

            exp_breq = (owner >= 0) && req[owner];
            if (exp_breq) begin
                case (phase)
                    0: ack = ($urandom_range(9) < 3);
                    1: ack = 1'b0;
                    2: ack = 1'b1;
                    default: ack = (age == TO - 1);
                endcase
            end else begin
                ack = 1'($urandom_range(1));
            end
            rdata = 8'($urandom_range(255));
            drive();
            #1;

            if (cyc % 500 == 250 && owner >= 0) begin
                rst = 1'b1;
                bif.bus_ack = 1'b1;
                #1;
                check("midrst_bus_req", 32'(bif.bus_req), 32'd0);
                check("midrst_grant_valid", 32'(grant_valid), 32'd0);
                check("midrst_grant_idx", 32'(grant_idx), 32'd0);
                check("midrst_m_ack", 32'(bif.m_ack), 32'd0);
                check("midrst_m_err", 32'(bif.m_err), 32'd0);
                owner = -1; age = 0; ptr = 0; last = 0;
                continue;
            end

            exp_drive = 12'd0;
            exp_ack   = '0;
            exp_err   = '0;
            if (owner >= 0) begin
                exp_drive = {addr[owner], wr[owner], wd[owner]};
                if (exp_breq && ack) exp_ack[owner] = 1'b1;
                if (exp_breq && !ack && age == TO - 1) exp_err[owner] = 1'b1;
            end
            check("bus_req", 32'(bif.bus_req), 32'(exp_breq));
            check("bus_drive", {20'd0, bif.bus_addr, bif.bus_write, bif.bus_wdata}, {20'd0, exp_drive});
            check("m_ack", 32'(bif.m_ack), 32'(exp_ack));
            check("m_err", 32'(bif.m_err), 32'(exp_err));
            check("m_rdata", 32'(bif.m_rdata), 32'(rdata));
            check("grant_valid", 32'(grant_valid), 32'(owner >= 0));
            check("grant_idx", 32'(grant_idx), 32'(last));

            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && req[(ptr + k) % N]) begin
                        owner = (ptr + k) % N;
                        last  = owner;
                        age   = 0;
                    end
                end
            end else if (!req[owner]) begin
                ptr = (owner + 1) % N;
                owner = -1;
            end else if (ack || age == TO - 1) begin
                req[owner] = 1'b0;
                ptr = (owner + 1) % N;
                owner = -1;
            end else begin
                age++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
